// File: rtl/sync_fifo_drain_arb.sv
// Purpose: round-robin read scheduler draining N upstream FIFOs into one output stream.
// Latency: a read issued in cycle t appears on out_valid/out_data/out_src in cycle t+2.
// Backpressure: out_a_full blocks rd_en in the same cycle it is sampled; the grant is held, never preempted.
//
// Ports:
//   clk, rst      - single rising-edge clock, synchronous active-high reset
//   fifo_empty    - per-FIFO empty flags (bit i = FIFO i)
//   fifo_rd_data  - per-FIFO read data, FIFO i at [i*DATA_W +: DATA_W]
//   fifo_rd_en    - per-FIFO read enable, at most one bit high
//   out_a_full    - almost-full flag of the downstream sink
//   out_valid     - out_data/out_src valid (sink write enable)
//   out_data      - drained word
//   out_src       - index of the FIFO the word came from
//   busy          - a grant is currently held
module sync_fifo_drain_arb #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int BURST  = 4,
  parameter int SRC_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        fifo_empty,
  input  logic [N*DATA_W-1:0] fifo_rd_data,
  output logic [N-1:0]        fifo_rd_en,
  input  logic                out_a_full,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [SRC_W-1:0]    out_src,
  output logic                busy
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             v1;
  logic [SRC_W-1:0] s1;

  logic              hi_found;
  logic [SRC_W-1:0]  hi_pick;
  logic [SRC_W-1:0]  lo_pick;
  logic [SRC_W-1:0]  pick;
  logic              gnt_empty;
  logic              issue;
  logic [DATA_W-1:0] rd_mux;
  logic [SRC_W-1:0]  ptr_next;

  // Cyclic search from ptr without a modulo: lowest non-empty index at or
  // above ptr wins; otherwise the lowest non-empty index below ptr.
  // Iterating downwards lets the last overwrite be the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!fifo_empty[i]) begin
        if (SRC_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_pick  = SRC_W'(i);
        end else begin
          lo_pick = SRC_W'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  // Decodes of the granted FIFO and of the stage-1 source for the data mux.
  always_comb begin
    gnt_empty = 1'b1;
    rd_mux    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SRC_W'(i)) gnt_empty = fifo_empty[i];
      if (s1 == SRC_W'(i))    rd_mux    = fifo_rd_data[i*DATA_W +: DATA_W];
    end
  end

  // rst gates the read so no word leaves an upstream FIFO during reset.
  assign issue    = (state == ST_BURST) && !gnt_empty && !out_a_full && !rst;
  assign ptr_next = (grant == SRC_LAST) ? '0 : grant + 1'b1;
  assign busy     = (state == ST_BURST);

  always_comb begin
    fifo_rd_en = '0;
    for (int i = 0; i < N; i++) begin
      fifo_rd_en[i] = issue && (grant == SRC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      v1        <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!(&fifo_empty)) begin
            grant <= pick;
            cnt   <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= ST_IDLE;
              ptr   <= ptr_next;
            end
          end else if (gnt_empty) begin
            state <= ST_IDLE;
            ptr   <= ptr_next;
          end
          // out_a_full alone: hold grant and count.
        end
        default: state <= ST_IDLE;
      endcase

      // Stage 1 tracks the issued read; stage 2 captures the FIFO output
      // that appears the cycle after rd_en.
      v1        <= issue;
      s1        <= grant;
      out_valid <= v1;
      out_src   <= s1;
      out_data  <= rd_mux;
    end
  end

endmodule
